// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_sampler
// Purpose  : Oversampling UART receiver (8N1). The line is double-flop
//            synchronized, each bit is decided by a 2-of-3 majority around the
//            bit centre, and the result is reported as a one-clock data_valid
//            or frame_error strobe.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_sampler #(
  parameter int SYS_CLOCK  = 1000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_input,
  output logic [7:0] data_output,
  output logic       data_valid,
  output logic       frame_error,
  output logic       busy
);

  // Tick divider; a ratio below one is clamped so ticks never stop.
  localparam int c_DIV_RAW = SYS_CLOCK / (BAUD_RATE * OVERSAMPLE);
  localparam int c_DIV     = (c_DIV_RAW < 1) ? 1 : c_DIV_RAW;
  localparam int c_DW      = (c_DIV > 1) ? $clog2(c_DIV) : 1;
  localparam int c_SW      = $clog2(OVERSAMPLE);

  localparam logic [c_DW-1:0] c_DIV_LAST = c_DW'(c_DIV - 1);
  localparam logic [c_SW-1:0] c_SMP_LAST = c_SW'(OVERSAMPLE - 1);
  // The three vote samples straddle the bit centre.
  localparam logic [c_SW-1:0] c_SMP_A    = c_SW'(OVERSAMPLE / 2 - 1);
  localparam logic [c_SW-1:0] c_SMP_B    = c_SW'(OVERSAMPLE / 2);
  localparam logic [c_SW-1:0] c_SMP_C    = c_SW'(OVERSAMPLE / 2 + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_sync1;
  logic              r_sync2;
  logic [c_DW-1:0]   r_div_cnt;
  logic [c_SW-1:0]   r_smp_cnt;
  logic [2:0]        r_bit_cnt;
  logic              r_samp_a;
  logic              r_samp_b;
  logic [7:0]        r_shift;
  logic [7:0]        r_data;
  logic              r_valid;
  logic              r_ferr;

  logic              w_rx;
  logic              w_tick;
  logic              w_vote;
  logic              w_wrap;
  logic              w_maj;
  logic              w_shift;
  logic              w_load;
  logic              w_ferr;

  assign w_rx   = r_sync2;
  assign w_tick = (r_div_cnt == c_DIV_LAST);
  assign w_vote = w_tick && (r_smp_cnt == c_SMP_C);
  assign w_wrap = w_tick && (r_smp_cnt == c_SMP_LAST);
  // Third vote sample is the live synchronized value at the decision tick.
  assign w_maj  = (r_samp_a & r_samp_b) | (r_samp_a & w_rx) | (r_samp_b & w_rx);

  // Two-flop synchronizer for the asynchronous serial line; idles high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_input;
      r_sync2 <= r_sync1;
    end
  end

  // Free-running sample-tick divider.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_cnt <= '0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state and datapath control.
  always_comb begin
    w_next  = r_state;
    w_shift = 1'b0;
    w_load  = 1'b0;
    w_ferr  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_tick && !w_rx) w_next = ST_START;
      end
      ST_START: begin
        // A start bit that votes high was a glitch: drop it silently.
        if (w_vote && w_maj)  w_next = ST_IDLE;
        else if (w_wrap)      w_next = ST_DATA;
      end
      ST_DATA: begin
        if (w_vote) w_shift = 1'b1;
        if (w_wrap && (r_bit_cnt == 3'd7)) w_next = ST_STOP;
      end
      ST_STOP: begin
        if (w_vote) begin
          if (w_maj) begin
            w_load = 1'b1;
            w_next = ST_IDLE;
          end else begin
            w_ferr = 1'b1;
            w_next = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        // Wait out a break / stuck-low line before re-arming start detection.
        if (w_tick && w_rx) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Sample and bit counters; the sample counter is held at zero while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_smp_cnt <= '0;
      r_bit_cnt <= '0;
    end else begin
      if (r_state == ST_IDLE) begin
        r_smp_cnt <= '0;
      end else if (w_tick) begin
        r_smp_cnt <= (r_smp_cnt == c_SMP_LAST) ? '0 : r_smp_cnt + 1'b1;
      end
      if (r_state == ST_START) begin
        r_bit_cnt <= '0;
      end else if ((r_state == ST_DATA) && w_wrap) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
    end
  end

  // Vote samples, LSB-first shift register, output byte and strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_samp_a <= 1'b1;
      r_samp_b <= 1'b1;
      r_shift  <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      if (w_tick && (r_smp_cnt == c_SMP_A)) r_samp_a <= w_rx;
      if (w_tick && (r_smp_cnt == c_SMP_B)) r_samp_b <= w_rx;
      if (w_shift) r_shift <= {w_maj, r_shift[7:1]};
      if (w_load)  r_data  <= r_shift;
      r_valid <= w_load;
      r_ferr  <= w_ferr;
    end
  end

  assign data_output = r_data;
  assign data_valid  = r_valid;
  assign frame_error = r_ferr;
  // The strobe cycle follows the return to IDLE, so keep busy up through it.
  assign busy        = (r_state != ST_IDLE) | r_valid | r_ferr;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_sampler.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_sampler
// Purpose  : Scoreboard bench for uart_rx_sampler. Stimulus serializes bytes
//            onto the line and queues the expected outcome; a monitor pops
//            and compares on every data_valid / frame_error strobe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_sampler;

  localparam int SYS_CLOCK  = 1536000;
  localparam int BAUD_RATE  = 9600;
  localparam int OVERSAMPLE = 16;
  localparam int BIT_CLK    = 160;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_input = 1'b1;
  logic [7:0] data_output;
  logic       data_valid;
  logic       frame_error;
  logic       busy;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] model_last = 8'h00;
  logic       busy_chk_pend = 1'b0;
  logic       busy_chk_exp = 1'b0;

  uart_rx_sampler #(
    .SYS_CLOCK (SYS_CLOCK),
    .BAUD_RATE (BAUD_RATE),
    .OVERSAMPLE(OVERSAMPLE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_input   (rx_input),
    .data_output(data_output),
    .data_valid (data_valid),
    .frame_error(frame_error),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      busy_chk_pend = 1'b0;
    end else begin
      if (busy_chk_pend) begin
        check("busy_after_strobe", 32'(busy), 32'(busy_chk_exp));
        busy_chk_pend = 1'b0;
      end
      if (data_valid || frame_error) begin
        check("strobe_exclusive", 32'(data_valid & frame_error), 32'd0);
        check("busy_during_strobe", 32'(busy), 32'd1);
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_strobe: valid=%0b ferr=%0b data=%02h, no strobe expected",
                   data_valid, frame_error, data_output);
        end else begin
          e = sb_q.pop_front();
          check("strobe_kind_ferr", 32'(frame_error), 32'(e.err));
          check("data_output", 32'(data_output), 32'(e.data));
        end
        // After a good frame the line is idle (busy drops); after a framing
        // error the line is still held low, so the receiver stays busy.
        busy_chk_pend = 1'b1;
        busy_chk_exp  = frame_error;
      end
    end
  end

  task automatic drive_bit(input logic v, input int n);
    rx_input = v;
    repeat (n) @(negedge clk);
  endtask

  // Serialize one 8N1 frame. A bad stop bit holds the line low for 3 bit times.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int spike_bit);
    exp_t e;
    if (stop_ok) begin
      e.err = 1'b0;
      e.data = b;
      model_last = b;
    end else begin
      e.err = 1'b1;
      e.data = model_last;
    end
    sb_q.push_back(e);
    drive_bit(1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      if (i == spike_bit) begin
        drive_bit(b[i], 75);
        drive_bit(~b[i], 10);
        drive_bit(b[i], 75);
      end else begin
        drive_bit(b[i], BIT_CLK);
      end
    end
    if (stop_ok) drive_bit(1'b1, BIT_CLK);
    else         drive_bit(1'b0, 3 * BIT_CLK);
    rx_input = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int max_clk);
    int k = 0;
    while (sb_q.size() != 0 && k < max_clk) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(sb_q.size()), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] rb;
    int         gap;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_data_output", 32'(data_output), 32'h00);
    check("rst_data_valid", 32'(data_valid), 32'd0);
    check("rst_frame_error", 32'(frame_error), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    drive_bit(1'b1, 2 * BIT_CLK);

    // Single good frame
    send_frame(8'hA5, 1'b1, -1);
    wait_drain("drain_A5", 4 * BIT_CLK);

    // Back-to-back frames, no idle gap
    send_frame(8'h80, 1'b1, -1);
    send_frame(8'h3C, 1'b1, -1);
    wait_drain("drain_80_3C", 4 * BIT_CLK);

    // Short low glitch on an idle line
    drive_bit(1'b1, BIT_CLK);
    drive_bit(1'b0, 40);
    drive_bit(1'b1, 120);
    check("glitch_busy_low", 32'(busy), 32'd0);
    drive_bit(1'b1, 100);
    check("glitch_data_hold", 32'(data_output), 32'(model_last));

    // Framing error, then recovery
    send_frame(8'h55, 1'b0, -1);
    drive_bit(1'b1, 2 * BIT_CLK);
    check("ferr_data_hold", 32'(data_output), 32'(model_last));
    send_frame(8'h0F, 1'b1, -1);
    wait_drain("drain_55_0F", 4 * BIT_CLK);

    // Reset in the middle of bit 4 of 8'hFF
    drive_bit(1'b1, BIT_CLK);
    drive_bit(1'b0, BIT_CLK);
    drive_bit(1'b1, 4 * BIT_CLK + 80);
    reset = 1'b1;
    model_last = 8'h00;
    repeat (3) @(negedge clk);
    check("midrst_data_output", 32'(data_output), 32'h00);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(data_valid), 32'd0);
    reset = 1'b0;
    drive_bit(1'b1, 2 * BIT_CLK);
    send_frame(8'h12, 1'b1, -1);
    wait_drain("drain_12", 4 * BIT_CLK);

    // One-sample spike in the middle of bit 3 of 8'h00
    send_frame(8'h00, 1'b1, 3);
    wait_drain("drain_spike", 4 * BIT_CLK);

    // Random bytes with random gaps, some back-to-back
    for (int n = 0; n < 8; n++) begin
      rb  = 8'($urandom);
      gap = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 400));
      send_frame(rb, 1'b1, -1);
      drive_bit(1'b1, gap);
    end
    wait_drain("drain_random", 4 * BIT_CLK);

    drive_bit(1'b1, 2 * BIT_CLK);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_sampler.md
UART_RX_SAMPLER -- requirements
Module: uart_rx_sampler

Interface
REQ-001 SHALL have parameter SYS_CLOCK, default 1000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, line bit rate in baud.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, sample ticks per bit (even, >= 8).
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port rx_input  input  1  serial line, idle high, asynchronous to clk.
REQ-007 SHALL have port data_output  output  8  last correctly framed byte.
REQ-008 SHALL have port data_valid  output  1  one-clk strobe: new byte on data_output.
REQ-009 SHALL have port frame_error  output  1  one-clk strobe: stop bit sampled low.
REQ-010 SHALL have port busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-011 SHALL pass rx_input through a 2-flop synchronizer (both flops reset to 1); all logic uses the synchronized value only.
REQ-012 SHALL generate a sample tick every DIV = SYS_CLOCK/(BAUD_RATE*OVERSAMPLE) clocks (integer divide, minimum 1); tick counter free-runs from reset.
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP, BREAK_WAIT.
REQ-014 IDLE: on a tick with synchronized line low -> START, sample counter cleared to 0.
REQ-015 Sample counter SHALL increment once per tick, wrapping at OVERSAMPLE-1 -> 0.
REQ-016 Each bit value SHALL be the 2-of-3 majority of the samples at counts OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1.
REQ-017 START: at count OVERSAMPLE/2+1, majority 0 -> remain in START until wrap, then DATA; majority 1 -> IDLE (glitch rejected, no strobe).
REQ-018 DATA: 8 bits, LSB first, shifted into an internal register; after bit 7 wraps -> STOP.
REQ-019 STOP: at count OVERSAMPLE/2+1, majority 1 -> load data_output from the shift register, pulse data_valid for exactly one clk, go to IDLE.
REQ-020 STOP: majority 0 -> pulse frame_error for exactly one clk, leave data_output unchanged, go to BREAK_WAIT.
REQ-021 BREAK_WAIT: remain until synchronized line high on a tick, then IDLE; no new start is detected while in BREAK_WAIT.
REQ-022 data_valid and frame_error SHALL never be high in the same cycle.
REQ-023 busy SHALL be high from the clk after IDLE->START through the cycle of the data_valid/frame_error strobe, inclusive.
REQ-024 Receive latency SHALL be 9.5 bit periods (+ tick quantization and 2 sync clocks) from the falling start edge to the strobe.
REQ-025 A back-to-back frame (start bit immediately after stop-bit midpoint) SHALL be received without loss.

Reset
REQ-026 On reset assertion, regardless of state: FSM -> IDLE, data_output = 8'h00, data_valid = 0, frame_error = 0, busy = 0, counters = 0, synchronizer = 1.
REQ-027 Reset mid-frame SHALL discard the partial byte; no strobe on or after deassertion until a complete new frame.

Verification (SYS_CLOCK=1536000, BAUD_RATE=9600, OVERSAMPLE=16 -> DIV=10, 160 clk/bit)
REQ-028 Frame 8'hA5, valid stop -> data_valid one clk, data_output=8'hA5, busy low next clk.
REQ-029 Frames 8'h80 then 8'h3C back-to-back, no idle gap -> two data_valid strobes, values 80 then 3C.
REQ-030 Low glitch of 40 clk on idle line -> no strobe, busy returns low within 1 bit period, data_output unchanged.
REQ-031 Frame 8'h55 with stop bit low, line held low 3 bit periods then high -> one frame_error, no data_valid, data_output holds prior value, next frame 8'h0F received correctly.
REQ-032 Reset asserted during bit 4 of 8'hFF, released, then frame 8'h12 -> only one data_valid, data_output=8'h12.
REQ-033 Single-sample (10 clk) inverted spike at a bit midpoint of 8'h00 -> majority vote yields data_output=8'h00.
